// File: rtl/keypad_entry.sv
`default_nettype none
// keypad_entry: debounced 10-key entry with BCD load strobe and a 3-digit shadow.
// Optional macro KEYPAD_BEEP_EN adds a beep pulse output.  Rev 1.0
module keypad_entry #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int CNT_W          = 2,
  parameter int BEEP_TICKS     = 10
) (
  input  logic       clk_100Hz,
  input  logic       clearn,
  input  logic [0:9] keypad,
  input  logic       enablen,
  output logic [3:0] bcd,
  output logic       loadn,
  output logic [3:0] entry_min,
  output logic [3:0] entry_sec_tens,
  output logic [3:0] entry_sec_ones,
  output logic [1:0] digit_count,
  output logic       key_reject
`ifdef KEYPAD_BEEP_EN
  ,
  output logic       beep
`endif
);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > (1 << CNT_W) || BEEP_TICKS < 1) begin : g_param_check
    $error("keypad_entry: invalid DEBOUNCE_TICKS/CNT_W/BEEP_TICKS");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       cand, cand_n;
  logic [3:0]       key_idx;
  logic             key_one, key_none;
  logic             load_go, reject_go;

  always_comb begin
    key_idx = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (keypad[k]) key_idx = 4'(k);
    end
  end

  assign key_one  = $onehot(keypad);
  assign key_none = (keypad == 10'd0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cand_n    = cand;
    load_go   = 1'b0;
    reject_go = 1'b0;
    case (state)
      IDLE: begin
        if (!enablen && key_one) begin
          cand_n  = key_idx;
          cnt_n   = '0;
          state_n = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (enablen || !key_one) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (key_idx != cand) begin
          cand_n = key_idx;
          cnt_n  = '0;
        end else if (cnt == LAST) begin
          state_n   = ACCEPT;
          load_go   = (digit_count != 2'd3);
          reject_go = (digit_count == 2'd3);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ACCEPT: begin
        cnt_n   = '0;
        state_n = RELEASE;
      end
      RELEASE: begin
        if (!key_none) begin
          cnt_n = '0;
        end else if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered on the edge into ACCEPT so loadn/key_reject are
  // active exactly while the FSM sits in ACCEPT.
  always_ff @(posedge clk_100Hz or negedge clearn) begin
    if (!clearn) begin
      state          <= IDLE;
      cnt            <= '0;
      cand           <= 4'd0;
      bcd            <= 4'd0;
      loadn          <= 1'b1;
      key_reject     <= 1'b0;
      entry_min      <= 4'd0;
      entry_sec_tens <= 4'd0;
      entry_sec_ones <= 4'd0;
      digit_count    <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cand       <= cand_n;
      loadn      <= !load_go;
      key_reject <= reject_go;
      if (load_go) begin
        bcd            <= cand;
        entry_min      <= entry_sec_tens;
        entry_sec_tens <= entry_sec_ones;
        entry_sec_ones <= cand;
        digit_count    <= digit_count + 2'd1;
      end
    end
  end

`ifdef KEYPAD_BEEP_EN
  localparam int BW = $clog2(BEEP_TICKS + 1);
  logic [BW-1:0] beep_cnt;

  always_ff @(posedge clk_100Hz or negedge clearn) begin
    if (!clearn) begin
      beep_cnt <= '0;
    end else if (state == ACCEPT) begin
      beep_cnt <= BW'(BEEP_TICKS);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BW'(1);
    end
  end

  assign beep = (beep_cnt != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// tb_keypad_entry: directed stimulus with a strobe/reject scoreboard for keypad_entry.
module tb_keypad_entry;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic [0:9] keypad = '0;
  logic       enablen = 1'b0;
  logic [3:0] bcd, entry_min, entry_sec_tens, entry_sec_ones;
  logic       loadn, key_reject;
  logic [1:0] digit_count;
`ifdef KEYPAD_BEEP_EN
  logic       beep;
`endif

  keypad_entry dut (
    .clk_100Hz      (clk),
    .clearn         (clearn),
    .keypad         (keypad),
    .enablen        (enablen),
    .bcd            (bcd),
    .loadn          (loadn),
    .entry_min      (entry_min),
    .entry_sec_tens (entry_sec_tens),
    .entry_sec_ones (entry_sec_ones),
    .digit_count    (digit_count),
    .key_reject     (key_reject)
`ifdef KEYPAD_BEEP_EN
    ,
    .beep           (beep)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rej;
    logic [3:0] digit;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rej, input logic [3:0] d);
    exp_t e;
    e.rej   = rej;
    e.digit = d;
    q.push_back(e);
  endtask

  task automatic press(input int k, input int hold, input int gap);
    keypad    = '0;
    keypad[k] = 1'b1;
    tick(hold);
    keypad = '0;
    tick(gap);
  endtask

  task automatic do_reset();
    keypad  = '0;
    enablen = 1'b0;
    clearn  = 1'b0;
    tick(2);
    clearn = 1'b1;
    tick(1);
  endtask

  // Monitor: every strobe or reject must match the oldest expected event.
  always @(negedge clk) begin
    if (clearn && (!loadn || key_reject)) begin
      exp_t e;
      chk("overlap", 32'(!loadn && key_reject), 0);
      if (q.size() == 0) begin
        chk("unexpected_event", 32'(q.size()), 1);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(key_reject), 32'(e.rej));
        if (!e.rej) chk("strobe_bcd", 32'(bcd), 32'(e.digit));
      end
    end
  end

  initial begin
    clearn = 1'b0;
    tick(2);
    chk("rst_loadn", 32'(loadn), 1);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_reject", 32'(key_reject), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_digits", {20'd0, entry_min, entry_sec_tens, entry_sec_ones}, 0);
    clearn = 1'b1;
    tick(1);

    // Single press of 5: strobe exactly DEBOUNCE_TICKS+1 cycles after the edge.
    push(1'b0, 4'd5);
    keypad[5] = 1'b1;
    tick(3);
    chk("lat_early", 32'(loadn), 1);
    tick(1);
    chk("lat_strobe", 32'(loadn), 0);
    chk("lat_bcd", 32'(bcd), 5);
    tick(1);
    chk("lat_pulse_end", 32'(loadn), 1);
`ifdef KEYPAD_BEEP_EN
    chk("beep_on", 32'(beep), 1);
`endif
    tick(5);
    keypad = '0;
    tick(6);
    chk("t1_ones", 32'(entry_sec_ones), 5);
    chk("t1_count", 32'(digit_count), 1);
    chk("t1_pending", 32'(q.size()), 0);

    // Three digits fill the shadow; a fourth is rejected.
    do_reset();
    push(1'b0, 4'd1);
    push(1'b0, 4'd3);
    push(1'b0, 4'd0);
    press(1, 10, 6);
    press(3, 10, 6);
    press(0, 10, 6);
    chk("t2_min", 32'(entry_min), 1);
    chk("t2_tens", 32'(entry_sec_tens), 3);
    chk("t2_ones", 32'(entry_sec_ones), 0);
    chk("t2_count", 32'(digit_count), 3);
    push(1'b1, 4'd0);
    press(7, 10, 6);
    chk("t2_rej_min", 32'(entry_min), 1);
    chk("t2_rej_tens", 32'(entry_sec_tens), 3);
    chk("t2_rej_ones", 32'(entry_sec_ones), 0);
    chk("t2_rej_count", 32'(digit_count), 3);
    chk("t2_pending", 32'(q.size()), 0);

    // Bounce on key 2 yields nothing; a steady hold yields one strobe.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      keypad[2] = (i % 2 == 0);
      tick(1);
    end
    keypad = '0;
    tick(5);
    chk("t3_bounce_count", 32'(digit_count), 0);
    push(1'b0, 4'd2);
    press(2, 10, 6);
    chk("t3_count", 32'(digit_count), 1);

    // Two keys together are ignored; dropping to one key accepts it.
    keypad[3] = 1'b1;
    keypad[4] = 1'b1;
    tick(20);
    chk("t4_multi_count", 32'(digit_count), 1);
    push(1'b0, 4'd4);
    keypad[3] = 1'b0;
    tick(10);
    keypad = '0;
    tick(6);
    chk("t4_tens", 32'(entry_sec_tens), 2);
    chk("t4_ones", 32'(entry_sec_ones), 4);
    chk("t4_count", 32'(digit_count), 2);
    chk("t4_pending", 32'(q.size()), 0);

    // Lock: no entry while enablen is high, abort mid-debounce, shadow kept.
    enablen = 1'b1;
    press(9, 10, 6);
    enablen   = 1'b0;
    keypad[6] = 1'b1;
    tick(2);
    enablen = 1'b1;
    tick(10);
    keypad = '0;
    tick(6);
    chk("t5_count", 32'(digit_count), 2);
    chk("t5_tens", 32'(entry_sec_tens), 2);
    chk("t5_ones", 32'(entry_sec_ones), 4);
    enablen = 1'b0;
    tick(2);

    // Async reset in the ACCEPT cycle clears everything at once.
    keypad[8] = 1'b1;
    tick(4);
    chk("t6_in_accept", 32'(loadn), 0);
    clearn = 1'b0;
    #1;
    chk("t6_loadn", 32'(loadn), 1);
    chk("t6_bcd", 32'(bcd), 0);
    chk("t6_count", 32'(digit_count), 0);
    chk("t6_digits", {20'd0, entry_min, entry_sec_tens, entry_sec_ones}, 0);
`ifdef KEYPAD_BEEP_EN
    chk("t6_beep", 32'(beep), 0);
`endif
    keypad = '0;
    tick(2);
    clearn = 1'b1;
    tick(4);
    chk("final_pending", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
